// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and state encoding
// for the UART command sequencer.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_REG_WR  = 8'hAA;
   localparam logic [7:0] CMD_REG_RD  = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_ALU_A,
      ST_ALU_B,
      ST_ALU_FUN,
      ST_ALU_WAIT,
      ST_TX_B0,
      ST_TX_B1
   } state_t;

endpackage

// File: rtl/sys_ctrl_tx_push.sv
// Response buffer (1 or 2 bytes) and TX FIFO push sequencer.
// Ports: load/len2/byte0/byte1 in, fifo_full in; wr_data/wr_inc out, done out.
module sys_ctrl_tx_push #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          len2,
   input  logic [DW-1:0] byte0,
   input  logic [DW-1:0] byte1,
   input  logic          fifo_full,
   output logic [DW-1:0] wr_data,
   output logic          wr_inc,
   output logic          done
);

   logic [DW-1:0] rb0;
   logic [DW-1:0] rb1;
   logic          busy;
   logic          idx;
   logic          two;

   // High in the cycle the final byte is committed for pushing.
   assign done = busy & ~fifo_full & (idx | ~two);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb0     <= '0;
         rb1     <= '0;
         busy    <= 1'b0;
         idx     <= 1'b0;
         two     <= 1'b0;
         wr_data <= '0;
         wr_inc  <= 1'b0;
      end else begin
         wr_inc <= 1'b0;
         if (load) begin
            rb0  <= byte0;
            rb1  <= byte1;
            two  <= len2;
            idx  <= 1'b0;
            busy <= 1'b1;
         end else if (busy && !fifo_full) begin
            wr_inc  <= 1'b1;
            wr_data <= idx ? rb1 : rb0;
            idx     <= 1'b1;
            if (done)
               busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sys_ctrl.sv
// UART command sequencer: decodes RX frames into regfile/ALU ops and queues responses.
// Ports: RX byte stream, regfile and ALU handshakes in; strobes, data, FIFO push, CMD_ERR out.
module sys_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DATAWIDTH   = 8,
   parameter int ADDRWIDTH   = 4,
   parameter int FUNWIDTH    = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [DATAWIDTH-1:0]   RX_P_DATA,
   input  logic                   RX_D_VLD,
   input  logic [DATAWIDTH-1:0]   RdData,
   input  logic                   RdData_Valid,
   input  logic [2*DATAWIDTH-1:0] ALU_OUT,
   input  logic                   OUT_Valid,
   input  logic                   FIFO_FULL,
   output logic [ADDRWIDTH-1:0]   Address,
   output logic                   WrEn,
   output logic                   RdEn,
   output logic [DATAWIDTH-1:0]   WrData,
   output logic                   ALU_EN,
   output logic [FUNWIDTH-1:0]    ALU_FUN,
   output logic                   CLK_EN,
   output logic [DATAWIDTH-1:0]   WR_DATA,
   output logic                   WR_INC,
   output logic                   CMD_ERR
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   state_t state, state_n;

   logic [CW-1:0]        cnt, cnt_n;
   logic [ADDRWIDTH-1:0] addr_n;
   logic [DATAWIDTH-1:0] wdata_n;
   logic [FUNWIDTH-1:0]  fun_n;
   logic                 wren_n, rden_n, alu_en_n;
   logic                 clk_en_n, cmd_err_n;
   logic                 load, len2, done;
   logic [DATAWIDTH-1:0] b0, b1;
   logic                 timeout;

   // Last wait cycle: abort takes effect on the next edge.
   assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         Address <= '0;
         WrData  <= '0;
         ALU_FUN <= '0;
         WrEn    <= 1'b0;
         RdEn    <= 1'b0;
         ALU_EN  <= 1'b0;
         CLK_EN  <= 1'b0;
         CMD_ERR <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         Address <= addr_n;
         WrData  <= wdata_n;
         ALU_FUN <= fun_n;
         WrEn    <= wren_n;
         RdEn    <= rden_n;
         ALU_EN  <= alu_en_n;
         CLK_EN  <= clk_en_n;
         CMD_ERR <= cmd_err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = '0;
      addr_n    = Address;
      wdata_n   = WrData;
      fun_n     = ALU_FUN;
      wren_n    = 1'b0;
      rden_n    = 1'b0;
      alu_en_n  = 1'b0;
      clk_en_n  = CLK_EN;
      cmd_err_n = 1'b0;
      load      = 1'b0;
      len2      = 1'b0;
      b0        = '0;
      b1        = '0;
      unique case (state)
         ST_IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  DATAWIDTH'(CMD_REG_WR):  state_n = ST_WR_ADDR;
                  DATAWIDTH'(CMD_REG_RD):  state_n = ST_RD_ADDR;
                  DATAWIDTH'(CMD_ALU_OP):  state_n = ST_ALU_A;
                  DATAWIDTH'(CMD_ALU_NOP): state_n = ST_ALU_FUN;
                  default:                 state_n = ST_IDLE;
               endcase
            end
         end
         ST_WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_n  = RX_P_DATA[ADDRWIDTH-1:0];
               state_n = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (RX_D_VLD) begin
               wren_n  = 1'b1;
               wdata_n = RX_P_DATA;
               state_n = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (RX_D_VLD) begin
               rden_n  = 1'b1;
               addr_n  = RX_P_DATA[ADDRWIDTH-1:0];
               state_n = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (RdData_Valid) begin
               load    = 1'b1;
               b0      = RdData;
               state_n = ST_TX_B0;
            end else if (timeout) begin
               cmd_err_n = 1'b1;
               state_n   = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_ALU_A: begin
            if (RX_D_VLD) begin
               wren_n  = 1'b1;
               addr_n  = ADDRWIDTH'(OPA_ADDR);
               wdata_n = RX_P_DATA;
               state_n = ST_ALU_B;
            end
         end
         ST_ALU_B: begin
            if (RX_D_VLD) begin
               wren_n  = 1'b1;
               addr_n  = ADDRWIDTH'(OPB_ADDR);
               wdata_n = RX_P_DATA;
               state_n = ST_ALU_FUN;
            end
         end
         ST_ALU_FUN: begin
            if (RX_D_VLD) begin
               fun_n    = RX_P_DATA[FUNWIDTH-1:0];
               alu_en_n = 1'b1;
               clk_en_n = 1'b1;
               state_n  = ST_ALU_WAIT;
            end
         end
         ST_ALU_WAIT: begin
            if (OUT_Valid) begin
               load     = 1'b1;
               len2     = 1'b1;
               b0       = ALU_OUT[DATAWIDTH-1:0];
               b1       = ALU_OUT[2*DATAWIDTH-1:DATAWIDTH];
               clk_en_n = 1'b0;
               state_n  = ST_TX_B0;
            end else if (timeout) begin
               cmd_err_n = 1'b1;
               clk_en_n  = 1'b0;
               state_n   = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_TX_B0: begin
            if (done)
               state_n = ST_IDLE;
            else if (!FIFO_FULL)
               state_n = ST_TX_B1;
         end
         ST_TX_B1: begin
            if (done)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   sys_ctrl_tx_push #(
      .DW (DATAWIDTH)
   ) u_tx_push (
      .clk       (CLK),
      .rst_n     (RST),
      .load      (load),
      .len2      (len2),
      .byte0     (b0),
      .byte1     (b1),
      .fifo_full (FIFO_FULL),
      .wr_data   (WR_DATA),
      .wr_inc    (WR_INC),
      .done      (done)
   );

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer between the UART and the register file, ALU and TX FIFO.
- Receives command frames byte-by-byte from the synchronized UART RX path.
- Issues register-file writes and reads, and ALU operations.
- Pushes response bytes into the TX FIFO, which the UART transmitter drains.
- Single clock domain (reference/system clock).

Parameters:
DATAWIDTH, 8, UART byte / register-file data width
ADDRWIDTH, 4, register-file address width
FUNWIDTH, 4, ALU function code width
TIMEOUT_CYC, 255, max cycles waiting for RdData_Valid or OUT_Valid before abort

Ports:
CLK  in  1  system clock, single clock domain
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATAWIDTH  received byte from data synchronizer
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RdData  in  DATAWIDTH  register-file read data
RdData_Valid  in  1  read data valid pulse
ALU_OUT  in  2*DATAWIDTH  ALU result
OUT_Valid  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full
Address  out  ADDRWIDTH  register-file address
WrEn  out  1  register-file write strobe
RdEn  out  1  register-file read strobe
WrData  out  DATAWIDTH  register-file write data
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  FUNWIDTH  ALU function code
CLK_EN  out  1  ALU clock-gate enable
WR_DATA  out  DATAWIDTH  byte pushed to TX FIFO
WR_INC  out  1  TX FIFO push strobe
CMD_ERR  out  1  one-cycle pulse on timeout abort

Behaviour:
- All outputs are registered. Reset value of every output is 0. Async RST low forces IDLE and clears the latched address, function code, result buffer and timeout counter, including mid-frame.
- Opcodes in IDLE, sampled on RX_D_VLD:
  - 0xAA: register write, frame AA,addr,data
  - 0xBB: register read, frame BB,addr
  - 0xCC: ALU with operands, frame CC,A,B,fun
  - 0xDD: ALU without operands, frame DD,fun
  - Any other byte: ignored, stay IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDRWIDTH-1:0] and go to WR_DATA.
- WR_DATA: on RX_D_VLD in cycle n, assert WrEn=1 in cycle n+1 for exactly 1 cycle, with the latched Address and WrData=byte. Then IDLE.
- RD_ADDR: on RX_D_VLD in cycle n, assert RdEn=1 in cycle n+1 for 1 cycle, with Address=byte. Then RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData as byte0, go to TX_B0 with a 1-byte response.
- ALU_A / ALU_B: on RX_D_VLD, write the byte to address 0 / 1. Same WrEn timing as WR_DATA.
- ALU_FUN: on RX_D_VLD in cycle n, latch the function code; in cycle n+1 assert ALU_EN=1 for 1 cycle with ALU_FUN valid. Then ALU_WAIT.
- CLK_EN: set in the cycle ALU_EN asserts; cleared in the cycle after the ALU result is captured or on abort.
- ALU_WAIT: on OUT_Valid, capture ALU_OUT. byte0=low byte, byte1=high byte, 2-byte response. Go to TX_B0.
- TX_B0 / TX_B1: each cycle with FIFO_FULL=0, emit WR_INC=1 for 1 cycle with WR_DATA=current byte and advance. While FIFO_FULL=1, hold state with WR_INC=0.
  - After byte0 of a 1-byte response: IDLE.
  - After byte0 of a 2-byte response: TX_B1, then IDLE.
  - Never push while full; a full FIFO stalls indefinitely (no timeout).
- Timeout: counter cleared on entry to RD_WAIT / ALU_WAIT, incremented each cycle there. On reaching TIMEOUT_CYC: pulse CMD_ERR for 1 cycle, clear CLK_EN, go to IDLE, push nothing.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_B0 or TX_B1: byte dropped, state unchanged.
- RX_D_VLD and RdData_Valid/OUT_Valid in the same cycle: the valid input wins and the RX byte is dropped.
- WrEn, RdEn and ALU_EN are mutually exclusive and never asserted together.

Decomposition:
- Shared package holds:
  - Opcode constants: CMD_REG_WR=0xAA, CMD_REG_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD.
  - ALU operand addresses: OPA_ADDR=0, OPB_ADDR=1.
  - State encoding typedef.
- One sub-module, sys_ctrl_tx_push: 2-byte response buffer plus FIFO push sequencer with the FIFO_FULL stall. Inputs are load, length (1/2) and bytes; output is done.

Test Plan:
- Write: RX bytes AA,05,3C -> one-cycle WrEn with Address=5, WrData=0x3C, one cycle after the 0x3C RX_D_VLD; nothing pushed to the FIFO.
- Read: RX bytes BB,05; RdData=0x3C with RdData_Valid 3 cycles after RdEn -> RdEn pulse with Address=5; single WR_INC with WR_DATA=0x3C; back to IDLE.
- ALU: RX bytes CC,12,34,02; ALU_OUT=0x0468 with OUT_Valid -> writes to addr 0=0x12 and addr 1=0x34; ALU_EN with ALU_FUN=2; CLK_EN high through capture; FIFO pushes 0x68 then 0x04.
- Backpressure: DD,01 with FIFO_FULL=1 held for 10 cycles after OUT_Valid -> no WR_INC while full; both bytes pushed on consecutive cycles after FIFO_FULL drops.
- Timeout/garbage: RX byte 0x77 -> ignored; BB,02 with no RdData_Valid -> CMD_ERR pulse exactly TIMEOUT_CYC cycles after entering RD_WAIT, IDLE, no push.
- Reset mid-frame: assert RST after AA,03 -> outputs 0 immediately; a subsequent 0x55 byte is ignored; a fresh AA,03,55 writes 0x55 to addr 3.
